// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined WIDTH-bit bitwise unit (op 0..7: NOT a, AND, OR, XOR, NAND, NOR, XNOR, PASS a); in_valid/in_ready/in_a/in_b/in_op in, out_valid/out_ready/out_data/out_zr/out_ng/out_count out through a one-entry skid buffer; define LOGIC_UNIT_PARITY_EN to add out_par
module logic_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_zr,
  output logic                 out_ng,
  output logic [CNT_WIDTH-1:0] out_count
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic                 out_par
`endif
);
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] ld;
  logic             accept;
  logic             out_free;
  logic             load;
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign load     = out_free && (skid_valid || accept);
  assign ld       = skid_valid ? skid_data : res;
  always_comb begin
    res = in_op == 3'd0 ? ~in_a :
          in_op == 3'd1 ? in_a & in_b :
          in_op == 3'd2 ? in_a | in_b :
          in_op == 3'd3 ? in_a ^ in_b :
          in_op == 3'd4 ? ~(in_a & in_b) :
          in_op == 3'd5 ? ~(in_a | in_b) :
          in_op == 3'd6 ? ~(in_a ^ in_b) : in_a;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_zr     <= 1'b0;
      out_ng     <= 1'b0;
      out_count  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (out_valid && out_ready) out_count <= out_count + 1'b1;
      if (out_free) begin
        out_valid  <= skid_valid || accept;
        skid_valid <= 1'b0;
        if (load) begin
          out_data <= ld;
          out_zr   <= ld == '0;
          out_ng   <= ld[WIDTH-1];
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= res;
      end
    end
  end
`ifdef LOGIC_UNIT_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) out_par <= 1'b0;
    else if (load) out_par <= ^ld;
  end
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;
  logic        clk = 0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_zr, out_ng;
  logic [15:0] in_a, in_b, out_data;
  logic [2:0]  in_op;
  logic [3:0]  out_count;
  logic        v8, r8, rdy8, ov8, zr8, ng8;
  logic [7:0]  a8, d8;
  logic [2:0]  op8;
  logic [15:0] cnt8;
  int checks = 0;
  int errors = 0;
  logic [15:0] sweep [8];
`ifdef LOGIC_UNIT_PARITY_EN
  logic par16, par8;
`endif
  always #5 clk = ~clk;
  logic_unit_pipe #(.WIDTH(16), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zr(out_zr),
    .out_ng(out_ng), .out_count(out_count)
`ifdef LOGIC_UNIT_PARITY_EN
    , .out_par(par16)
`endif
  );
  logic_unit_pipe #(.WIDTH(8), .CNT_WIDTH(16)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
    .in_a(a8), .in_b(8'h00), .in_op(op8), .out_valid(ov8),
    .out_ready(rdy8), .out_data(d8), .out_zr(zr8),
    .out_ng(ng8), .out_count(cnt8)
`ifdef LOGIC_UNIT_PARITY_EN
    , .out_par(par8)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    sweep = '{16'hC33C, 16'h1000, 16'h3EF7, 16'h2EF7, 16'hEFFF, 16'hC108, 16'hD108, 16'h3CC3};
    rst_n = 0; in_valid = 0; out_ready = 1; in_a = 0; in_b = 0; in_op = 0;
    v8 = 0; rdy8 = 1; a8 = 0; op8 = 0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_zr", out_zr, 0);
    chk("rst_ng", out_ng, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1; in_valid = 1; in_a = 16'h0000; in_op = 0;
    v8 = 1; a8 = 8'h5A; op8 = 0;
    tick();
    chk("not_valid", out_valid, 1);
    chk("not_data", out_data, 16'hFFFF);
    chk("not_zr", out_zr, 0);
    chk("not_ng", out_ng, 1);
    chk("w8_data", d8, 8'hA5);
    chk("w8_ng", ng8, 1);
`ifdef LOGIC_UNIT_PARITY_EN
    chk("w8_par", par8, 0);
    chk("not_par", par16, 0);
`endif
    in_valid = 0; v8 = 0;
    tick();
    chk("not_count", out_count, 1);
    chk("not_drain", out_valid, 0);
    in_a = 16'h3CC3; in_b = 16'h1234; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_op = 3'(i);
      chk("sweep_ready", in_ready, 1);
      tick();
      chk($sformatf("sweep_op%0d", i), out_data, sweep[i]);
      chk("sweep_valid", out_valid, 1);
    end
    in_valid = 0;
    tick();
    chk("sweep_count", out_count, 9);
    in_a = 16'hF0F0; in_b = 16'h0F0F; in_op = 1; in_valid = 1;
    tick();
    chk("zero_data", out_data, 0);
    chk("zero_zr", out_zr, 1);
    chk("zero_ng", out_ng, 0);
    in_valid = 0;
    tick();
    chk("zero_count", out_count, 10);
    out_ready = 0; in_valid = 1; in_a = 16'hAAAA; in_op = 0;
    tick();
    chk("bp_first", out_data, 16'h5555);
    chk("bp_ready1", in_ready, 1);
    in_a = 16'h1234;
    tick();
    chk("bp_hold", out_data, 16'h5555);
    chk("bp_ready0", in_ready, 0);
    in_a = 16'h0F0F;
    tick();
    chk("bp_hold2", out_data, 16'h5555);
    chk("bp_ng_hold", out_ng, 0);
    chk("bp_ready_still0", in_ready, 0);
    out_ready = 1;
    tick();
    chk("bp_second", out_data, 16'hEDCB);
    chk("bp_ready_back", in_ready, 1);
    tick();
    chk("bp_third", out_data, 16'hF0F0);
    in_valid = 0;
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_count", out_count, 13);
    out_ready = 0; in_valid = 1; in_a = 16'h1111;
    tick(); tick();
    chk("mid_skid_full", in_ready, 0);
    rst_n = 0; in_valid = 0;
    tick();
    chk("mid_valid", out_valid, 0);
    chk("mid_ready", in_ready, 1);
    chk("mid_count", out_count, 0);
    rst_n = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_stale", out_valid, 0);
    end
    in_valid = 1;
    for (int i = 0; i < 17; i++) begin
      in_a = 16'(i);
      tick();
      if (i == 16) chk("wrap_zero", out_count, 0);
    end
    in_valid = 0;
    tick();
    chk("wrap_count", out_count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined successor to the fixed 16-bit bitwise gates. Performs one of eight bitwise operations on two WIDTH-bit operands. Results are registered behind a valid/ready handshake with a one-entry skid buffer, so the block can sit between ALU front-end stages without dropping data under backpressure. Status flags (zr, ng) and a completed-transfer counter are also registered.

Parameters:
WIDTH, 16, operand/result width in bits; legal range 1..64.
CNT_WIDTH, 16, width of the completed-transfer counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
in_valid  input  1  upstream offers an operation.
in_ready  output  1  block can accept; equals NOT skid_valid (register-derived, no combinational path from out_ready).
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_op  input  3  0 NOT a, 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS a.
out_valid  output  1  result available.
out_ready  input  1  downstream accepts the result.
out_data  output  WIDTH  result.
out_zr  output  1  out_data == 0.
out_ng  output  1  out_data[WIDTH-1].
out_count  output  CNT_WIDTH  number of completed output transfers (out_valid & out_ready), modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst_n low at an edge): out_valid=0, out_data=0, out_zr=0, out_ng=0, out_count=0, skid empty. in_ready therefore reads 1 from the first cycle after reset. Inputs are ignored while rst_n is low. Reset mid-transfer discards both output and skid contents.
- Accept: accept = in_valid & in_ready at an edge. Result is computed combinationally from in_a/in_b/in_op and captured at that edge. in_b is ignored for ops 0 and 7.
- Latency: an accepted operation at edge k appears on out_valid/out_data at edge k, i.e. visible during cycle k+1 when the output register is free.
- Output register loading (priority order each edge):
  1. out empty, or out transferring (out_valid & out_ready), with skid full: out <= skid, skid empties.
  2. out empty, or out transferring, with skid empty and accept: out <= new result.
  3. out holding (out_valid & !out_ready) and accept: skid <= new result; in_ready drops next cycle.
  4. out transferring, nothing pending: out_valid <= 0.
- Simultaneous transfer and accept with skid empty gives full throughput, one result per cycle.
- Skid full: in_ready=0. Upstream must hold. A new accept is never possible while skid is full, so no overflow case exists.
- Ordering is strictly FIFO: skid contents always leave before any newer accept.
- Stability: while out_valid & !out_ready, out_data, out_zr and out_ng are unchanged.
- Flags are computed from the value loaded into out_data and registered with it.
- out_count increments by 1 on each edge with out_valid & out_ready. It wraps from all-ones to 0 with no saturation.
- Widths: all ops are pure bitwise on WIDTH bits; no carries, no truncation.

Optional Feature:
LOGIC_UNIT_PARITY_EN
- Defined: adds output port out_par (1 bit) = XOR-reduction of out_data. It is registered with out_data, resets to 0, and holds under backpressure like the other flags.
- Not defined: the port does not exist and no parity logic is generated. All other behaviour is identical.

Test Plan:
- Reset then NOT: WIDTH=16, rst_n low for 2 cycles, then in_a=0x0000, op=0, out_ready=1 -> next cycle out_data=0xFFFF, out_zr=0, out_ng=1, out_count=1 after the transfer edge.
- Op sweep: in_a=0x3CC3, in_b=0x1234, ops 0..7 back-to-back with out_ready=1 -> 0xC33C, 0x1000, 0x3EF7, 0x2EF7, 0xEFFF, 0xC108, 0xD108, 0x3CC3, one per cycle, in_ready held 1.
- Backpressure: out_ready=0, issue 0xAAAA NOT, then 0x1234 NOT -> out_data=0x5555 held; second result goes to skid; in_ready=0. Third request is held off. Raise out_ready -> 0x5555, 0xEDCB, then third result, in order with none lost.
- Zero flag: AND 0xF0F0 & 0x0F0F -> out_data=0x0000, out_zr=1, out_ng=0.
- Counter wrap: CNT_WIDTH=4, 17 transfers -> out_count=1.
- Reset mid-operation: skid full, pull rst_n low one edge -> out_valid=0, in_ready=1, out_count=0. No stale result emerges. WIDTH=8 instance: NOT 0x5A -> 0xA5; with LOGIC_UNIT_PARITY_EN, out_par=0.
